// File: rtl/glyph_dma_sched.sv
// Font glyph ROM scheduler: one DMA window per line during horizontal blanking,
// serving requesting sprites in ascending index order with a latency-matched one-hot grant.
module glyph_dma_sched #(
    parameter int SPR_CNT   = 14,
    parameter int CORDW     = 16,
    parameter int ADDRW     = 9,
    parameter int LINEW     = 3,
    parameter int DMA_START = -28,
    parameter int ROM_LAT   = 1
) (
    input  logic                       clk_pix,
    input  logic                       rst_pix_n,
    input  logic signed [CORDW-1:0]    sx,
    input  logic                       frame,
    input  logic [SPR_CNT-1:0]         req,
    input  logic [SPR_CNT*ADDRW-1:0]   glyph_base,
    input  logic [SPR_CNT*LINEW-1:0]   glyph_line,
    output logic [ADDRW-1:0]           rom_addr,
    output logic [SPR_CNT-1:0]         grant,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDXW = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;
    localparam logic signed [CORDW-1:0] OPEN_SX = CORDW'(DMA_START);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [SPR_CNT-1:0]   pend_r;
    logic [SPR_CNT-1:0]   pend_nxt_s;
    logic [SPR_CNT-1:0]   pend_clr_s;
    logic [SPR_CNT-1:0]   sel_oh_s;
    logic [SPR_CNT-1:0]   push_s;
    logic [SPR_CNT-1:0]   pipe_r [ROM_LAT];
    logic [IDXW-1:0]      sel_s;
    logic                 sel_vld_s;
    logic [ADDRW-1:0]     base_sel_s;
    logic [LINEW-1:0]     line_sel_s;
    logic [ADDRW-1:0]     sum_s;
    logic [ADDRW-1:0]     addr_nxt_s;
    logic                 busy_nxt_s;
    logic                 ovr_set_s;
    logic                 flush_s;
    logic                 pipe_empty_s;
    logic                 open_s;
    logic                 deadline_s;

    function automatic logic [IDXW-1:0] lowest_idx(input logic [SPR_CNT-1:0] v);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int i = SPR_CNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    // Priority pick of the lowest pending sprite and its glyph line address.
    always_comb begin
        sel_s      = lowest_idx(pend_r);
        sel_vld_s  = |pend_r;
        sel_oh_s   = {SPR_CNT{1'b0}};
        sel_oh_s[sel_s] = sel_vld_s;
        base_sel_s = glyph_base[int'(sel_s) * ADDRW +: ADDRW];
        line_sel_s = glyph_line[int'(sel_s) * LINEW +: LINEW];
        sum_s      = base_sel_s + ADDRW'(line_sel_s);
        pend_clr_s = pend_r & ~sel_oh_s;
        open_s     = (sx == OPEN_SX);
        deadline_s = (sx == {CORDW{1'b0}});
    end

    // Grant pipeline occupancy; the output grant register is not part of it.
    always_comb begin
        pipe_empty_s = 1'b1;
        for (int k = 0; k < ROM_LAT; k++) begin
            if (pipe_r[k] != {SPR_CNT{1'b0}}) begin
                pipe_empty_s = 1'b0;
            end else begin
                pipe_empty_s = pipe_empty_s;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        busy_nxt_s  = busy;
        addr_nxt_s  = rom_addr;
        push_s      = {SPR_CNT{1'b0}};
        ovr_set_s   = 1'b0;
        flush_s     = 1'b0;
        if (open_s) begin
            // A window opening over a live one means DMA_START is misplaced.
            if (state_r != IDLE) begin
                ovr_set_s = 1'b1;
                flush_s   = 1'b1;
            end else begin
                ovr_set_s = 1'b0;
                flush_s   = 1'b0;
            end
            pend_nxt_s  = req;
            busy_nxt_s  = 1'b1;
            state_nxt_s = ISSUE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ISSUE: begin
                    if (sel_vld_s) begin
                        addr_nxt_s = sum_s;
                        push_s     = sel_oh_s;
                        pend_nxt_s = pend_clr_s;
                        if (deadline_s && (pend_clr_s != {SPR_CNT{1'b0}})) begin
                            ovr_set_s  = 1'b1;
                            pend_nxt_s = {SPR_CNT{1'b0}};
                        end else begin
                            ovr_set_s  = 1'b0;
                        end
                        if (deadline_s || (pend_clr_s == {SPR_CNT{1'b0}})) begin
                            state_nxt_s = DRAIN;
                        end else begin
                            state_nxt_s = ISSUE;
                        end
                    end else if (pipe_empty_s) begin
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty_s) begin
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
                default: begin
                    pend_nxt_s  = {SPR_CNT{1'b0}};
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, pending mask and grant pipeline.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            rom_addr <= {ADDRW{1'b0}};
            grant    <= {SPR_CNT{1'b0}};
            busy     <= 1'b0;
            overrun  <= 1'b0;
            pend_r   <= {SPR_CNT{1'b0}};
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_r[k] <= {SPR_CNT{1'b0}};
            end
        end else begin
            rom_addr <= addr_nxt_s;
            pend_r   <= pend_nxt_s;
            busy     <= busy_nxt_s;
            if (ovr_set_s) begin
                overrun <= 1'b1;
            end else if (frame) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
            if (flush_s) begin
                grant <= {SPR_CNT{1'b0}};
                for (int k = 0; k < ROM_LAT; k++) begin
                    pipe_r[k] <= {SPR_CNT{1'b0}};
                end
            end else begin
                pipe_r[0] <= push_s;
                for (int k = 1; k < ROM_LAT; k++) begin
                    pipe_r[k] <= pipe_r[k-1];
                end
                grant <= pipe_r[ROM_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_glyph_dma_sched.sv
// Bench for glyph_dma_sched: three configurations share stimulus; a per-line
// service-list model predicts addresses, grants, busy and overrun cycle by cycle.
module tb_glyph_dma_sched;

    localparam int N  = 14;
    localparam int AW = 9;
    localparam int LW = 3;
    localparam int CW = 16;
    localparam int NI = 3;
    localparam int DS_T  [NI] = '{-28, -4, -28};
    localparam int LAT_T [NI] = '{1, 1, 2};
    localparam int NONE = 1000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic signed [CW-1:0]   sx;
    logic                   frame;
    logic [N-1:0]           req;
    logic [N*AW-1:0]        gbase;
    logic [N*LW-1:0]        gline;
    logic [AW-1:0]          addr_o  [NI];
    logic [N-1:0]           grant_o [NI];
    logic                   busy_o  [NI];
    logic                   ovr_o   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    int base_v [N];
    int line_v [N];
    int srv    [NI][N];
    int nsrv   [NI];
    int cur_addr [NI];
    bit exp_ovr  [NI];
    bit killed   [NI];

    always #5 clk = ~clk;

    glyph_dma_sched #(.SPR_CNT(N), .CORDW(CW), .ADDRW(AW), .LINEW(LW), .DMA_START(-28), .ROM_LAT(1)) u_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .frame(frame), .req(req),
        .glyph_base(gbase), .glyph_line(gline),
        .rom_addr(addr_o[0]), .grant(grant_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));

    glyph_dma_sched #(.SPR_CNT(N), .CORDW(CW), .ADDRW(AW), .LINEW(LW), .DMA_START(-4), .ROM_LAT(1)) u_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .frame(frame), .req(req),
        .glyph_base(gbase), .glyph_line(gline),
        .rom_addr(addr_o[1]), .grant(grant_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));

    glyph_dma_sched #(.SPR_CNT(N), .CORDW(CW), .ADDRW(AW), .LINEW(LW), .DMA_START(-28), .ROM_LAT(2)) u_c (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .frame(frame), .req(req),
        .glyph_base(gbase), .glyph_line(gline),
        .rom_addr(addr_o[2]), .grant(grant_o[2]), .busy(busy_o[2]), .overrun(ovr_o[2]));

    task automatic chk(input string tag, input int inst, input int s, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst=%0d sx=%0d got=%h exp=%h", tag, inst, s, obs, exp);
        end
    endtask

    // One display line sx=-40..10; frame_sx/rst_sx select the cycle of those pulses.
    task automatic run_line(input logic [N-1:0] r, input int frame_sx, input int rst_sx);
        int pop;
        int t;
        int lat;
        int ds;
        int idx;
        logic [N-1:0] eg;
        logic         eb;
        req = r;
        for (int i = 0; i < N; i++) begin
            gbase[i*AW +: AW] = AW'(base_v[i]);
            gline[i*LW +: LW] = LW'(line_v[i]);
        end
        pop = 0;
        for (int i = 0; i < N; i++) pop += int'(r[i]);
        for (int k = 0; k < NI; k++) begin
            nsrv[k]   = 0;
            killed[k] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (r[i] && nsrv[k] < -DS_T[k]) begin
                    srv[k][nsrv[k]] = i;
                    nsrv[k]++;
                end
            end
        end
        for (int s = -40; s <= 10; s++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                ds  = DS_T[k];
                lat = LAT_T[k];
                t   = s - ds;
                eg  = '0;
                eb  = 1'b0;
                if (!killed[k]) begin
                    if (t >= 2 && t - 2 < nsrv[k])
                        cur_addr[k] = (base_v[srv[k][t-2]] + line_v[srv[k][t-2]]) % 512;
                    idx = t - lat - 2;
                    if (idx >= 0 && idx < nsrv[k]) eg[srv[k][idx]] = 1'b1;
                    if (nsrv[k] > 0) eb = (t >= 1 && t <= nsrv[k] + lat + 1);
                    else             eb = (t == 1);
                end
                chk("rom_addr", k, s, 32'(addr_o[k]), 32'(cur_addr[k]));
                chk("grant",    k, s, 32'(grant_o[k]), 32'(eg));
                chk("busy",     k, s, 32'(busy_o[k]), 32'(eb));
                chk("overrun",  k, s, 32'(ovr_o[k]), 32'(exp_ovr[k]));
            end
            sx    = CW'(s);
            frame = (s == frame_sx);
            rst_n = (s == rst_sx) ? 1'b0 : 1'b1;
            for (int k = 0; k < NI; k++) begin
                t = s - DS_T[k];
                if (s == rst_sx) begin
                    cur_addr[k] = 0;
                    exp_ovr[k]  = 1'b0;
                    if (t >= 0) killed[k] = 1'b1;
                end else if (!killed[k] && pop > -DS_T[k] && t == -DS_T[k]) begin
                    exp_ovr[k] = 1'b1;
                end else if (s == frame_sx) begin
                    exp_ovr[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < N; i++) begin
            base_v[i] = int'($urandom_range(0, 511));
            line_v[i] = int'($urandom_range(0, 7));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sx    = CW'(-40);
        frame = 1'b0;
        req   = '0;
        gbase = '0;
        gline = '0;
        for (int k = 0; k < NI; k++) begin
            cur_addr[k] = 0;
            exp_ovr[k]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_addr",  k, -40, 32'(addr_o[k]), 32'd0);
            chk("rst_grant", k, -40, 32'(grant_o[k]), 32'd0);
            chk("rst_busy",  k, -40, 32'(busy_o[k]), 32'd0);
            chk("rst_ovr",   k, -40, 32'(ovr_o[k]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            base_v[i] = 8 * i;
            line_v[i] = 3;
        end
        run_line(14'h3FFF, NONE, NONE);
        run_line(14'b10_0000_0010_0001, -40, NONE);
        base_v[0] = 9'h1FE;
        line_v[0] = 5;
        run_line(14'h0001, NONE, NONE);
        run_line(14'h0003, NONE, NONE);
        run_line(14'h0000, NONE, NONE);
        run_line(14'h3FFF, NONE, -24);
        rand_tables();
        run_line(14'h3FFF, NONE, NONE);
        run_line(14'h00F1, 0, NONE);
        run_line(14'h0010, -40, NONE);
        for (int l = 0; l < 12; l++) begin
            int fsx;
            rand_tables();
            case ($urandom_range(0, 2))
                0:       fsx = -40;
                1:       fsx = 0;
                default: fsx = NONE;
            endcase
            run_line(N'($urandom), fsx, NONE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
